// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory arbiter slice.
package lc3_mem_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } arb_state_e;

  // One-hot bus owner encodings driven on grant
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;

  // Default build parameters
  localparam int DEF_MEM_LATENCY = 3;
  localparam int DEF_FAIR_LIMIT  = 4;

  // Width of the latency timer and fairness streak counter (covers 1..15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_latency_timer.sv
// Down-counting access timer: loaded at grant, decremented on every access
// cycle, flags the final access cycle.
module mem_latency_timer
  import lc3_mem_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_C = WIDTH'(0);

  logic [WIDTH-1:0] count_r;

  // Remaining access cycles; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= ZERO_C;
    end else if (load) begin
      count_r <= load_value;
    end else if (tick && (count_r != ZERO_C)) begin
      count_r <= count_r - ONE_C;
    end else begin
      count_r <= count_r;
    end
  end

  assign done = tick && (count_r == ONE_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter in front of a single-port memory array.
// One transaction at a time: IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP.
module mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int FAIR_LIMIT  = DEF_FAIR_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic [15:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [1:0]  grant
);

  localparam logic [CNT_W-1:0] LAT_C  = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] FAIR_C = CNT_W'(FAIR_LIMIT);

  arb_state_e       state_r, state_next_s;
  logic [1:0]       grant_r, grant_next_s;
  logic [CNT_W-1:0] streak_r, streak_next_s;

  logic             we_r;
  logic [15:0]      addr_r, wdata_r;
  logic [15:0]      cpu_rdata_r, dma_rdata_r;
  logic             mem_en_r, mem_we_r, cpu_ready_r, dma_ready_r;

  logic             start_s, capture_s, timer_tick_s, timer_done_s;
  logic             sel_we_s;
  logic [15:0]      sel_addr_s, sel_wdata_s;
  logic             mem_en_next_s, mem_we_next_s;
  logic             cpu_ready_next_s, dma_ready_next_s;

  assign timer_tick_s = (state_r == ST_ACCESS);

  mem_latency_timer #(.WIDTH(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_s),
    .load_value (LAT_C),
    .tick       (timer_tick_s),
    .done       (timer_done_s)
  );

  // Next-state, arbitration with CPU priority bounded by the fairness streak,
  // and the registered-output next values.
  always_comb begin
    state_next_s  = state_r;
    grant_next_s  = grant_r;
    streak_next_s = streak_r;
    start_s       = 1'b0;
    capture_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          start_s      = 1'b1;
          state_next_s = ST_ACCESS;
          if (cpu_req && !(dma_req && (streak_r == FAIR_C))) begin
            grant_next_s = GNT_CPU;
            if (dma_req) begin
              streak_next_s = (streak_r == FAIR_C) ? streak_r : (streak_r + 4'd1);
            end else begin
              streak_next_s = 4'd0;
            end
          end else begin
            grant_next_s  = GNT_DMA;
            streak_next_s = 4'd0;
          end
        end else begin
          state_next_s = ST_IDLE;
          grant_next_s = GNT_NONE;
        end
      end
      ST_ACCESS: begin
        if (timer_done_s) begin
          state_next_s = ST_RESP;
          capture_s    = !we_r;
        end else begin
          state_next_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
        grant_next_s = GNT_NONE;
      end
      default: begin
        state_next_s = ST_IDLE;
        grant_next_s = GNT_NONE;
      end
    endcase

    if (grant_next_s == GNT_DMA) begin
      sel_we_s    = dma_we;
      sel_addr_s  = dma_addr;
      sel_wdata_s = dma_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end

    mem_en_next_s    = (state_next_s == ST_ACCESS);
    mem_we_next_s    = mem_en_next_s && (start_s ? sel_we_s : we_r);
    cpu_ready_next_s = (state_r == ST_ACCESS) && timer_done_s && (grant_r == GNT_CPU);
    dma_ready_next_s = (state_r == ST_ACCESS) && timer_done_s && (grant_r == GNT_DMA);
  end

  // State, owner and fairness streak registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      grant_r  <= GNT_NONE;
      streak_r <= 4'd0;
    end else begin
      state_r  <= state_next_s;
      grant_r  <= grant_next_s;
      streak_r <= streak_next_s;
    end
  end

  // Latch the winner's request so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      addr_r  <= 16'h0000;
      wdata_r <= 16'h0000;
    end else if (start_s) begin
      we_r    <= sel_we_s;
      addr_r  <= sel_addr_s;
      wdata_r <= sel_wdata_s;
    end else begin
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Glitch-free memory strobes and one-cycle completion pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      cpu_ready_r <= 1'b0;
      dma_ready_r <= 1'b0;
    end else begin
      mem_en_r    <= mem_en_next_s;
      mem_we_r    <= mem_we_next_s;
      cpu_ready_r <= cpu_ready_next_s;
      dma_ready_r <= dma_ready_next_s;
    end
  end

  // Capture read data for the owner on the final access cycle; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_r <= 16'h0000;
      dma_rdata_r <= 16'h0000;
    end else if (capture_s && (grant_r == GNT_CPU)) begin
      cpu_rdata_r <= mem_rdata;
    end else if (capture_s && (grant_r == GNT_DMA)) begin
      dma_rdata_r <= mem_rdata;
    end else begin
      cpu_rdata_r <= cpu_rdata_r;
      dma_rdata_r <= dma_rdata_r;
    end
  end

  assign grant     = grant_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign cpu_ready = cpu_ready_r;
  assign dma_ready = dma_ready_r;
  assign cpu_rdata = cpu_rdata_r;
  assign dma_rdata = dma_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: default build plus a MEM_LATENCY=1 build.
module tb_mem_arbiter;
  import lc3_mem_pkg::*;

  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-latency DUT signals
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_ready, dma_ready, mem_en, mem_we;
  logic [1:0]  grant;

  // Latency-1 DUT signals
  logic        l1_cpu_req, l1_cpu_we, l1_dma_req, l1_dma_we;
  logic [15:0] l1_cpu_addr, l1_cpu_wdata, l1_dma_addr, l1_dma_wdata;
  logic [15:0] l1_cpu_rdata, l1_dma_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic        l1_cpu_ready, l1_dma_ready, l1_mem_en, l1_mem_we;
  logic [1:0]  l1_grant;

  // Memory content model: one fixed word, everything else address-derived
  function automatic logic [15:0] rd_model(input logic [15:0] a);
    if (a == 16'h3000) return 16'h1234;
    else return a ^ 16'h5A5A;
  endfunction

  assign mem_rdata    = rd_model(mem_addr);
  assign l1_mem_rdata = ~l1_mem_addr;

  mem_arbiter #(.MEM_LATENCY(LAT), .FAIR_LIMIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant(grant)
  );

  mem_arbiter #(.MEM_LATENCY(1), .FAIR_LIMIT(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(l1_cpu_req), .cpu_we(l1_cpu_we), .cpu_addr(l1_cpu_addr), .cpu_wdata(l1_cpu_wdata),
    .cpu_rdata(l1_cpu_rdata), .cpu_ready(l1_cpu_ready),
    .dma_req(l1_dma_req), .dma_we(l1_dma_we), .dma_addr(l1_dma_addr), .dma_wdata(l1_dma_wdata),
    .dma_rdata(l1_dma_rdata), .dma_ready(l1_dma_ready),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .grant(l1_grant)
  );

  typedef struct {
    bit          is_dma;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  gnt_q[$];
  logic [15:0] l1_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_cpu_rdata = 16'h0000;
  logic [15:0] exp_dma_rdata = 16'h0000;

  // One complete transaction, driven from an IDLE-cycle negedge; returns at
  // the negedge of the following IDLE cycle.
  task automatic run_txn(input bit is_dma, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit perturb);
    exp_t e, got;
    int cyc, en_cnt, lat;
    bit bus_ok, done, dma_pulsed;
    logic [1:0] gnt_seen;
    logic [15:0] obs, other_obs, other_exp;
    e.is_dma = is_dma; e.we = we; e.addr = addr; e.wdata = wdata;
    if (we) e.rdata = is_dma ? exp_dma_rdata : exp_cpu_rdata;
    else    e.rdata = rd_model(addr);
    exp_q.push_back(e);
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    cyc = 0; en_cnt = 0; lat = -1; bus_ok = 1'b1; done = 1'b0; dma_pulsed = 1'b0;
    gnt_seen = 2'b00;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) gnt_seen = grant;
      if (mem_en === 1'b1) begin
        en_cnt++;
        if (mem_addr !== addr || mem_we !== we || mem_wdata !== wdata) bus_ok = 1'b0;
      end
      if (perturb && cyc == 1) begin
        cpu_req = 1'b0; cpu_addr = ~addr; cpu_wdata = ~wdata; cpu_we = ~we;
      end
      if (cpu_ready === 1'b1 || dma_ready === 1'b1) begin
        done = 1'b1; lat = cyc; dma_pulsed = (dma_ready === 1'b1);
        cpu_req = 1'b0; dma_req = 1'b0;
      end
    end
    tests_run++;
    if (gnt_seen !== (is_dma ? GNT_DMA : GNT_CPU)) begin
      tests_failed++; $display("FAIL grant addr=%h: got %b expected %b", addr, gnt_seen, is_dma ? GNT_DMA : GNT_CPU);
    end
    tests_run++;
    if (lat !== LAT + 1) begin
      tests_failed++; $display("FAIL latency addr=%h: got %0d expected %0d", addr, lat, LAT + 1);
    end
    tests_run++;
    if (en_cnt !== LAT) begin
      tests_failed++; $display("FAIL mem_en_cycles addr=%h: got %0d expected %0d", addr, en_cnt, LAT);
    end
    tests_run++;
    if (!bus_ok) begin
      tests_failed++; $display("FAIL mem_bus addr=%h: bus differed from addr=%h we=%b wdata=%h", addr, addr, we, wdata);
    end
    got = exp_q.pop_front();
    tests_run++;
    if (dma_pulsed !== got.is_dma) begin
      tests_failed++; $display("FAIL ready_owner addr=%h: dma_pulsed=%b expected %b", addr, dma_pulsed, got.is_dma);
    end
    obs       = got.is_dma ? dma_rdata : cpu_rdata;
    other_obs = got.is_dma ? cpu_rdata : dma_rdata;
    other_exp = got.is_dma ? exp_cpu_rdata : exp_dma_rdata;
    tests_run++;
    if (obs !== got.rdata) begin
      tests_failed++; $display("FAIL rdata addr=%h: got %h expected %h", addr, obs, got.rdata);
    end
    tests_run++;
    if (other_obs !== other_exp) begin
      tests_failed++; $display("FAIL rdata_hold addr=%h: got %h expected %h", addr, other_obs, other_exp);
    end
    if (got.is_dma) exp_dma_rdata = got.rdata;
    else            exp_cpu_rdata = got.rdata;
    @(negedge clk);
    tests_run++;
    if (cpu_ready !== 1'b0 || dma_ready !== 1'b0 || grant !== GNT_NONE || mem_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_resp addr=%h: cpu_ready=%b dma_ready=%b grant=%b mem_en=%b expected 0,0,00,0",
               addr, cpu_ready, dma_ready, grant, mem_en);
    end
  endtask

  task automatic test_reset();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 16'h0000;
    l1_cpu_req = 1'b0; l1_cpu_we = 1'b0; l1_cpu_addr = 16'h0000; l1_cpu_wdata = 16'h0000;
    l1_dma_req = 1'b0; l1_dma_we = 1'b0; l1_dma_addr = 16'h0000; l1_dma_wdata = 16'h0000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (grant !== 2'b00 || mem_en !== 1'b0 || mem_we !== 1'b0 || cpu_ready !== 1'b0 || dma_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: grant=%b mem_en=%b mem_we=%b cpu_ready=%b dma_ready=%b expected all 0",
               grant, mem_en, mem_we, cpu_ready, dma_ready);
    end
    tests_run++;
    if (cpu_rdata !== 16'h0000 || dma_rdata !== 16'h0000 || mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_data: cpu_rdata=%h dma_rdata=%h mem_addr=%h mem_wdata=%h expected 0000",
               cpu_rdata, dma_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (grant !== GNT_NONE || mem_en !== 1'b0) begin
      tests_failed++; $display("FAIL idle_no_req: grant=%b mem_en=%b expected 00 0", grant, mem_en);
    end
  endtask

  task automatic test_cpu_read();
    run_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0);
  endtask

  task automatic test_dma_write();
    run_txn(1'b1, 1'b0, 16'h1111, 16'h0000, 1'b0);
    run_txn(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 1'b0);
  endtask

  task automatic test_patterns();
    run_txn(1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
    run_txn(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    run_txn(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
    run_txn(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_txn(1'(i % 2), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0);
    end
  endtask

  task automatic test_mid_change();
    run_txn(1'b0, 1'b0, 16'h2468, 16'h0000, 1'b1);
  endtask

  // Both requesters hold their requests; grants must follow C,C,C,C,D.
  task automatic test_fairness();
    logic [1:0] prev, exp_g;
    int cyc;
    for (int i = 0; i < 10; i++) gnt_q.push_back((i % 5 == 4) ? GNT_DMA : GNT_CPU);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 16'h0000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200; dma_wdata = 16'h0000;
    prev = grant;
    cyc = 0;
    while (gnt_q.size() > 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (grant !== GNT_NONE && prev === GNT_NONE) begin
        exp_g = gnt_q.pop_front();
        tests_run++;
        if (grant !== exp_g) begin
          tests_failed++; $display("FAIL fair_grant#%0d: got %b expected %b", 10 - gnt_q.size(), grant, exp_g);
        end
      end
      prev = grant;
    end
    tests_run++;
    if (gnt_q.size() != 0) begin
      tests_failed++; $display("FAIL fair_timeout: %0d grants missing expected 0", gnt_q.size());
      gnt_q.delete();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (8) @(negedge clk);
    exp_cpu_rdata = rd_model(16'h0100);
    exp_dma_rdata = rd_model(16'h0200);
    tests_run++;
    if (cpu_rdata !== exp_cpu_rdata || dma_rdata !== exp_dma_rdata || grant !== GNT_NONE) begin
      tests_failed++;
      $display("FAIL fair_rdata: cpu=%h dma=%h grant=%b expected %h %h 00",
               cpu_rdata, dma_rdata, grant, exp_cpu_rdata, exp_dma_rdata);
    end
  endtask

  // Reset asserted in the second access cycle abandons the transaction.
  task automatic test_reset_mid();
    int rdy;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4444; cpu_wdata = 16'h5555;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (grant !== 2'b00 || mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0000 ||
        mem_wdata !== 16'h0000 || cpu_ready !== 1'b0 || cpu_rdata !== 16'h0000 || dma_rdata !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_reset: grant=%b en=%b we=%b addr=%h wdata=%h ready=%b cpu_rdata=%h dma_rdata=%h expected all 0",
               grant, mem_en, mem_we, mem_addr, mem_wdata, cpu_ready, cpu_rdata, dma_rdata);
    end
    cpu_req = 1'b0;
    exp_cpu_rdata = 16'h0000;
    exp_dma_rdata = 16'h0000;
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_ready === 1'b1 || dma_ready === 1'b1) rdy++;
    end
    tests_run++;
    if (rdy != 0) begin
      tests_failed++; $display("FAIL reset_no_ready: got %0d pulses expected 0", rdy);
    end
    rst_n = 1'b1;
    run_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0);
  endtask

  // MEM_LATENCY=1 build: ready at N+2, held request gives one per 3 cycles.
  task automatic test_latency1();
    int cyc, last, nrdy;
    logic [15:0] e;
    for (int i = 0; i < 4; i++) l1_q.push_back(~16'h1357);
    l1_cpu_req = 1'b1; l1_cpu_we = 1'b0; l1_cpu_addr = 16'h1357; l1_cpu_wdata = 16'h0000;
    cyc = 0; last = 0; nrdy = 0;
    while (nrdy < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (l1_cpu_ready === 1'b1) begin
        nrdy++;
        e = l1_q.pop_front();
        tests_run++;
        if (l1_cpu_rdata !== e) begin
          tests_failed++; $display("FAIL l1_rdata#%0d: got %h expected %h", nrdy, l1_cpu_rdata, e);
        end
        tests_run++;
        if ((nrdy == 1 && cyc != 2) || (nrdy > 1 && cyc - last != 3)) begin
          tests_failed++;
          $display("FAIL l1_timing#%0d: got cycle %0d (prev %0d) expected %0d",
                   nrdy, cyc, last, (nrdy == 1) ? 2 : last + 3);
        end
        last = cyc;
        if (nrdy == 4) l1_cpu_req = 1'b0;
      end
    end
    tests_run++;
    if (nrdy != 4) begin
      tests_failed++; $display("FAIL l1_count: got %0d readies expected 4", nrdy);
    end
    l1_cpu_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_patterns();
    test_mid_change();
    test_fairness();
    test_reset_mid();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound in case a wait loop misbehaves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
